vga_fb_ctrl: RTL and testbench
==============================

VGA_FB_CTRL -- requirements
Module: vga_fb_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SCALE_SHIFT, default 2, log2 pixel replication; FB_W=H_ACTIVE>>SCALE_SHIFT, FB_H=V_ACTIVE>>SCALE_SHIFT.
REQ-006 SHALL have parameter SYNC_POL, default 0, asserted level of hsync/vsync.
REQ-007 clk  input  1  pixel clock, all logic rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 wr_valid  input  1  write request; wr_ready  output  1  write accept.
REQ-010 wr_x  input  10  write column; wr_y  input  9  write row; wr_data  input  12  RGB444 pixel.
REQ-011 swap_req  input  1  single-cycle request to exchange front/back buffers.
REQ-012 mode  input  1  0 = framebuffer, 1 = colour-bar test pattern.
REQ-013 hsync, vsync, valid  output  1 each  sync and active-video (blank_n).
REQ-014 vga_r, vga_g, vga_b  output  8 each  pixel colour.
REQ-015 front_sel  output  1  buffer being displayed; swap_done  output  1  one-cycle swap pulse; frame_start  output  1  first-pixel pulse.

Function
REQ-016 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrap to 0, and increment v_cnt on wrap; v_cnt wraps at V_TOTAL-1.
REQ-017 Region order per line/frame SHALL be active, front porch, sync, back porch; sync asserted while h_cnt (v_cnt) in [ACTIVE+FP, ACTIVE+FP+SYNC-1].
REQ-018 Two framebuffers of FB_W*FB_H x 12 bits SHALL exist; display reads buffer front_sel, writes target buffer ~front_sel.
REQ-019 Read address SHALL be (v_cnt>>SCALE_SHIFT)*FB_W + (h_cnt>>SCALE_SHIFT); memory read registered (1 cycle).
REQ-020 All outputs hsync, vsync, valid, rgb, frame_start SHALL be delayed by exactly 2 clk cycles from counter state, mutually aligned.
REQ-021 RGB444 SHALL expand to 8 bits per channel by nibble replication (0xA -> 0xAA).
REQ-022 Outside active region vga_r/g/b SHALL be 0 and valid 0.
REQ-023 mode=1 SHALL output 8 equal vertical bars of width H_ACTIVE/8, colours in order white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF/0x00); mode sampled every cycle.
REQ-024 Write SHALL occur on cycle with wr_valid && wr_ready; address wr_y*FB_W + wr_x.
REQ-025 Writes with wr_x>=FB_W or wr_y>=FB_H SHALL be accepted (handshake completes) and discarded.
REQ-026 swap_req SHALL set swap_pending; wr_ready SHALL be 0 while swap_pending, else 1.
REQ-027 Swap SHALL take effect at the cycle h_cnt=0, v_cnt=V_ACTIVE: front_sel toggles, swap_pending clears, swap_done pulses 1 cycle.
REQ-028 swap_req while already pending SHALL be ignored (one swap only).
REQ-029 swap_req coincident with the swap cycle SHALL be consumed by that swap; no second pending request.
REQ-030 frame_start SHALL pulse for one cycle aligned with output of pixel (0,0).

Reset
REQ-031 On rst: h_cnt=v_cnt=0, pipeline cleared, hsync=vsync=~SYNC_POL, valid=0, rgb=0, front_sel=0, swap_pending=0, swap_done=0, frame_start=0, wr_ready=0 while rst high then 1.
REQ-032 Framebuffer contents SHALL NOT be cleared by reset.
REQ-033 rst mid-frame SHALL restart timing at (0,0) on the first cycle after release; a pending swap is dropped.

Verification (bench params H 8/2/2/2, V 4/1/1/1, SCALE_SHIFT 1)
REQ-034 Release reset, run 2 frames -> hsync low for cycles 10-11 of each 14-cycle line (+2 offset), vsync low on line 5, valid high 8x4 region, frame_start every 98 cycles.
REQ-035 Write (x=1,y=0,data=0xF0A) to back, swap_req, wait swap_done -> next frame line 0 and 1, pixels 2-3 show r=0xFF g=0x00 b=0xAA, front_sel=1.
REQ-036 swap_req at line 1 -> wr_ready=0 until swap cycle (h=0,v=4), swap_done 1 cycle, second swap_req while pending -> front_sel toggles once only.
REQ-037 Write x=4 (FB_W=4) with wr_valid -> wr_ready high, no memory change, displayed frame unchanged.
REQ-038 mode=1 -> pixel 0 = 0xFFFFFF, pixel 7 = 0x000000, blanking rgb = 0.
REQ-039 Assert rst at h=5,v=2 for 3 cycles -> outputs at reset values immediately; timing restarts at (0,0), front_sel=0.

Source files
------------

// File: rtl/vga_fb_ctrl_if.sv
// Pixel write port into the back framebuffer: valid/ready handshake with
// column, row and RGB444 data.
interface vga_fb_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [11:0] wr_data;

  modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_ctrl.sv
// VGA timing generator with double-buffered, pixel-replicated RGB444
// framebuffer, colour-bar test mode and vblank-synchronised buffer swap.
module vga_fb_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  vga_fb_ctrl_if.slave       wr,
  input  logic               swap_req,
  input  logic               mode,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               front_sel,
  output logic               swap_done,
  output logic               frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H     = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int BAR_W    = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic [23:0] expand444(input logic [11:0] p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

  // Bar order white..black is the 3-bit index with inverted GRB weights.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pend_q, pend_d;
  logic          front_q, front_d;
  logic          done_q;
  logic          swap_now;

  logic [11:0]   fb0 [FB_DEPTH];
  logic [11:0]   fb1 [FB_DEPTH];

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // A request landing on the swap cycle itself is served by that swap.
  assign swap_now = (pend_q | swap_req) && (h_q == '0) && (v_q == V_ACT);

  always_comb begin
    pend_d  = pend_q;
    front_d = front_q;
    if (swap_now) begin
      pend_d  = 1'b0;
      front_d = ~front_q;
    end else if (swap_req) begin
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      pend_q  <= pend_d;
      front_q <= front_d;
      done_q  <= swap_now;
    end
  end

  assign front_sel   = front_q;
  assign swap_done   = done_q;
  assign wr.wr_ready = ~rst & ~pend_q;

  logic          wr_in_range, wr_en;
  logic [AW-1:0] waddr;

  assign wr_in_range = (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);
  assign wr_en       = wr.wr_valid & wr.wr_ready & wr_in_range;
  assign waddr       = AW'(32'(wr.wr_y) * FB_W + 32'(wr.wr_x));

  always_ff @(posedge clk) begin
    if (wr_en && front_q) fb0[waddr] <= wr.wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !front_q) fb1[waddr] <= wr.wr_data;
  end

  // ---- stage p0: decode from counter state
  logic          act_p0, hs_p0, vs_p0, fs_p0;
  logic [AW-1:0] raddr_p0;
  logic [2:0]    bar_p0;

  assign act_p0   = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_p0    = (h_q >= HS_BEG) && (h_q <= HS_END);
  assign vs_p0    = (v_q >= VS_BEG) && (v_q <= VS_END);
  assign fs_p0    = (h_q == '0) && (v_q == '0);
  assign raddr_p0 = act_p0 ? AW'(32'(v_q >> SCALE_SHIFT) * FB_W + 32'(h_q >> SCALE_SHIFT)) : '0;
  assign bar_p0   = 3'(32'(h_q) / BAR_W);

  // ---- stage p1: registered memory read, aligned control
  logic [11:0] pix_p1_q;
  logic [2:0]  bar_p1_q;
  logic        act_p1_q, hs_p1_q, vs_p1_q, fs_p1_q, mode_p1_q;
  logic [23:0] rgb_p1;

  always_ff @(posedge clk) begin
    pix_p1_q <= front_q ? fb1[raddr_p0] : fb0[raddr_p0];
    bar_p1_q <= bar_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
      fs_p1_q   <= 1'b0;
      mode_p1_q <= 1'b0;
    end else begin
      act_p1_q  <= act_p0;
      hs_p1_q   <= hs_p0;
      vs_p1_q   <= vs_p0;
      fs_p1_q   <= fs_p0;
      mode_p1_q <= mode;
    end
  end

  always_comb begin
    rgb_p1 = '0;
    if (act_p1_q) rgb_p1 = mode_p1_q ? bar_rgb(bar_p1_q) : expand444(pix_p1_q);
  end

  // ---- stage p2: output registers
  logic        hsync_p2_q, vsync_p2_q, act_p2_q, fs_p2_q;
  logic [23:0] rgb_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p2_q <= ~SYNC_POL;
      vsync_p2_q <= ~SYNC_POL;
      act_p2_q   <= 1'b0;
      fs_p2_q    <= 1'b0;
      rgb_p2_q   <= '0;
    end else begin
      hsync_p2_q <= hs_p1_q ? SYNC_POL : ~SYNC_POL;
      vsync_p2_q <= vs_p1_q ? SYNC_POL : ~SYNC_POL;
      act_p2_q   <= act_p1_q;
      fs_p2_q    <= fs_p1_q;
      rgb_p2_q   <= rgb_p1;
    end
  end

  assign hsync       = hsync_p2_q;
  assign vsync       = vsync_p2_q;
  assign valid       = act_p2_q;
  assign frame_start = fs_p2_q;
  assign vga_r       = rgb_p2_q[23:16];
  assign vga_g       = rgb_p2_q[15:8];
  assign vga_b       = rgb_p2_q[7:0];
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl on a 14x7 timing grid with 2x pixel replication.
module tb_vga_fb_ctrl;
  localparam int HA = 8, HFP = 2, HS = 2, HB = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VB = 1;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;
  localparam int FBW = 4, FBH = 2;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
    logic        fs;
  } vid_t;

  localparam vid_t BLANK = '{hs: 1'b1, vs: 1'b1, vld: 1'b0, rgb: 24'h0, fs: 1'b0};

  logic clk = 1'b0, rst = 1'b0, swap_req = 1'b0, mode = 1'b0;
  logic hsync, vsync, valid, front_sel, swap_done, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_fb_ctrl_if bus();

  vga_fb_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(1), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .wr(bus), .swap_req(swap_req), .mode(mode),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .front_sel(front_sel), .swap_done(swap_done), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference state: frame position, buffer contents, front/pending flags.
  int          pos;
  bit          m_front, m_pend;
  logic [11:0] fb [2][8];
  vid_t        exp_q [$];
  int          pos_q [$];
  int          cmp_pos;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vid_t model_pix(int p);
    vid_t e;
    int h, v;
    logic [11:0] d;
    h = p % HT;
    v = p / HT;
    e = BLANK;
    e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
    e.fs = (p == 0);
    if (h < HA && v < VA) begin
      e.vld = 1'b1;
      if (mode) e.rgb = BARS[h * 8 / HA];
      else begin
        d = fb[m_front][(v / 2) * FBW + h / 2];
        e.rgb = {8'(d[11:8] * 17), 8'(d[7:4] * 17), 8'(d[3:0] * 17)};
      end
    end
    return e;
  endfunction

  task automatic mreset();
    pos = 0;
    m_front = 1'b0;
    m_pend = 1'b0;
    exp_q.delete();
    pos_q.delete();
    exp_q.push_back(BLANK);
    pos_q.push_back(-1);
  endtask

  task automatic step();
    vid_t e;
    bit sw;
    exp_q.push_back(model_pix(pos));
    pos_q.push_back(pos);
    sw = 1'b0;
    if (bus.wr_valid && !m_pend && int'(bus.wr_x) < FBW && int'(bus.wr_y) < FBH)
      fb[!m_front][int'(bus.wr_y) * FBW + int'(bus.wr_x)] = bus.wr_data;
    if ((m_pend || swap_req) && pos == VA * HT) begin
      sw = 1'b1;
      m_front = !m_front;
      m_pend = 1'b0;
    end else if (swap_req) m_pend = 1'b1;
    pos = (pos + 1) % FT;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp_pos = pos_q.pop_front();
    chk($sformatf("video@%0d", cmp_pos),
        32'({hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start}), 32'(e));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("swap_done", 32'(swap_done), 32'(sw));
    chk("wr_ready", 32'(bus.wr_ready), 32'(!m_pend));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_px(int x, int y, logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_x = 10'(x);
    bus.wr_y = 9'(y);
    bus.wr_data = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic swap_pulse();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic run_until_swap(int limit);
    int k = 0;
    while (swap_done !== 1'b1 && k < limit) begin
      step();
      k++;
    end
    chk("swap_seen", 32'(swap_done), 32'd1);
  endtask

  task automatic step_to_pos(int target);
    int k = 0;
    while (pos != target && k < FT) begin
      step();
      k++;
    end
  endtask

  task automatic step_to_cmp(int target);
    int k = 0;
    step();
    while (cmp_pos != target && k < 2 * FT) begin
      step();
      k++;
    end
    chk("reach_cmp", 32'(cmp_pos), 32'(target));
  endtask

  task automatic rand_inputs();
    bus.wr_valid = 1'($urandom_range(0, 1));
    bus.wr_x = 10'($urandom_range(0, 5));
    bus.wr_y = 9'($urandom_range(0, 2));
    bus.wr_data = 12'($urandom);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_front"}, 32'(front_sel), 32'd0);
    chk({tag, "_done"}, 32'(swap_done), 32'd0);
    chk({tag, "_ready"}, 32'(bus.wr_ready), 32'd0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_x = '0;
    bus.wr_y = '0;
    bus.wr_data = '0;
    mode = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    mreset();

    // Two frames of colour bars while loading buffer 1, then swap and load buffer 0.
    for (int i = 0; i < 8; i++) write_px(i % 4, i / 4, 12'($urandom));
    run(2 * FT - 8);
    swap_pulse();
    run_until_swap(2 * FT);
    for (int i = 0; i < 8; i++) write_px(i % 4, i / 4, 12'($urandom));
    swap_pulse();
    run_until_swap(2 * FT);
    mode = 1'b0;
    run(FT);

    // Single pixel written to the back buffer becomes visible after the swap.
    write_px(1, 0, 12'hF0A);
    swap_pulse();
    run_until_swap(2 * FT);
    step_to_cmp(2);
    chk("px_2_0", 32'({vga_r, vga_g, vga_b}), 32'h00FF00AA);
    step();
    chk("px_3_0", 32'({vga_r, vga_g, vga_b}), 32'h00FF00AA);
    step_to_cmp(HT + 2);
    chk("px_2_1", 32'({vga_r, vga_g, vga_b}), 32'h00FF00AA);
    chk("front_after_swap", 32'(front_sel), 32'd1);

    // Swap requested on line 1, re-requested while pending: one toggle only.
    step_to_pos(HT);
    swap_pulse();
    chk("ready_pending", 32'(bus.wr_ready), 32'd0);
    while (pos != 2 * HT + 2) begin
      rand_inputs();
      step();
    end
    bus.wr_valid = 1'b0;
    swap_pulse();
    run_until_swap(2 * FT);
    chk("front_toggled", 32'(front_sel), 32'd0);
    run(FT);
    chk("single_swap", 32'(front_sel), 32'd0);

    // Out-of-range writes complete the handshake and change nothing.
    #0 chk("oob_x_ready", 32'(bus.wr_ready), 32'd1);
    write_px(4, 0, 12'h123);
    chk("oob_y_ready", 32'(bus.wr_ready), 32'd1);
    write_px(0, 2, 12'h456);
    run(FT);

    // Request arriving exactly on the swap cycle.
    step_to_pos(VA * HT);
    swap_pulse();
    chk("coincident_done", 32'(swap_done), 32'd1);
    step();
    chk("no_second_pend", 32'(bus.wr_ready), 32'd1);

    // Randomised traffic: writes (some out of range), swaps, mode flips.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      swap_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step();
    end
    bus.wr_valid = 1'b0;
    swap_req = 1'b0;
    mode = 1'b0;
    run(FT);

    // Mid-frame reset with a swap pending.
    step_to_pos(HT + 6);
    swap_pulse();
    step_to_pos(2 * HT + 5);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("hold_rst");
    mreset();
    rst = 1'b0;
    step_to_cmp(0);
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_front", 32'(front_sel), 32'd0);
    run(2 * FT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
